// File: rtl/io_gpio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : io_gpio_pkg
// Purpose  : Shared constants for the io_gpio peripheral: register offsets
//            within a bank, edge-sense encodings and the bank address stride.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package io_gpio_pkg;

    // Each bank occupies eight consecutive IO addresses.
    localparam int c_bank_stride = 8;

    // Register offsets inside a bank.
    localparam logic [2:0] c_off_dir      = 3'd0;
    localparam logic [2:0] c_off_out      = 3'd1;
    localparam logic [2:0] c_off_outset   = 3'd2;
    localparam logic [2:0] c_off_outclr   = 3'd3;
    localparam logic [2:0] c_off_outtgl   = 3'd4;
    localparam logic [2:0] c_off_in       = 3'd5;
    localparam logic [2:0] c_off_intmask  = 3'd6;
    localparam logic [2:0] c_off_intflags = 3'd7;

    // Interrupt edge-sense selection.
    localparam int c_edge_both = 0;
    localparam int c_edge_rise = 1;
    localparam int c_edge_fall = 2;

endpackage
`default_nettype wire

// File: rtl/io_gpio_bank.sv
`default_nettype none
// ============================================================================
// Module   : io_gpio_bank
// Purpose  : One 8-pin GPIO bank: DIR/OUT/INTMASK registers, atomic
//            set/clear/toggle, input synchroniser, edge detect and W1C flags.
// Ports    : clk, rst (async, active low)
//            i_sel       bank addressed by the current bus cycle
//            i_offset    register offset within the bank
//            i_re/i_we   bus read / write strobes
//            i_wdata     bus write data
//            i_blank     suppress flag setting (post-reset settling)
//            i_pin       raw pad inputs
//            o_rdata     read data, 8'h00 when not selected or not reading
//            o_pin_out   OUT register, o_pin_dir DIR register
//            o_int_pend  OR of (INTFLAGS & INTMASK)
// Revision : 1.0 - initial release
// ============================================================================
module io_gpio_bank
    import io_gpio_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter int         EDGE_MODE   = c_edge_both,
    parameter logic [7:0] OUT_RESET   = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_sel,
    input  logic [2:0] i_offset,
    input  logic       i_re,
    input  logic       i_we,
    input  logic [7:0] i_wdata,
    input  logic       i_blank,
    input  logic [7:0] i_pin,
    output logic [7:0] o_rdata,
    output logic [7:0] o_pin_out,
    output logic [7:0] o_pin_dir,
    output logic       o_int_pend
);

    logic [7:0]                  r_dir;
    logic [7:0]                  r_out;
    logic [7:0]                  r_mask;
    logic [7:0]                  r_flags;
    logic [SYNC_STAGES-1:0][7:0] r_sync;
    logic [7:0]                  r_prev;

    logic       w_wr;
    logic [7:0] w_in;
    logic [7:0] w_rise;
    logic [7:0] w_fall;
    logic [7:0] w_event;
    logic [7:0] w_set;
    logic [7:0] w_clr;
    logic [7:0] w_rd_mux;

    assign w_wr   = i_sel & i_we;
    assign w_in   = r_sync[SYNC_STAGES-1];
    assign w_rise = w_in & ~r_prev;
    assign w_fall = ~w_in & r_prev;

    always_comb begin
        case (EDGE_MODE)
            c_edge_rise: w_event = w_rise;
            c_edge_fall: w_event = w_fall;
            default:     w_event = w_rise | w_fall;
        endcase
    end

    // A flag set by an edge in the same cycle as its W1C clear survives,
    // because the set term is OR-ed in after the clear mask.
    assign w_set = i_blank ? 8'h00 : w_event;
    assign w_clr = (w_wr && (i_offset == c_off_intflags)) ? i_wdata : 8'h00;

    // Stage 0 takes the raw pad; the last stage is what software sees as IN.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync <= '0;
            r_prev <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
            r_prev <= w_in;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dir   <= 8'h00;
            r_out   <= OUT_RESET;
            r_mask  <= 8'h00;
            r_flags <= 8'h00;
        end else begin
            r_flags <= (r_flags & ~w_clr) | w_set;
            if (w_wr) begin
                case (i_offset)
                    c_off_dir:     r_dir  <= i_wdata;
                    c_off_out:     r_out  <= i_wdata;
                    c_off_outset:  r_out  <= r_out | i_wdata;
                    c_off_outclr:  r_out  <= r_out & ~i_wdata;
                    c_off_outtgl:  r_out  <= r_out ^ i_wdata;
                    c_off_intmask: r_mask <= i_wdata;
                    default:       ;
                endcase
            end
        end
    end

    // The atomic-op addresses read back OUT so read-modify-write code works.
    always_comb begin
        w_rd_mux = 8'h00;
        case (i_offset)
            c_off_dir:      w_rd_mux = r_dir;
            c_off_out,
            c_off_outset,
            c_off_outclr,
            c_off_outtgl:   w_rd_mux = r_out;
            c_off_in:       w_rd_mux = w_in;
            c_off_intmask:  w_rd_mux = r_mask;
            c_off_intflags: w_rd_mux = r_flags;
            default:        w_rd_mux = 8'h00;
        endcase
    end

    assign o_rdata    = (i_sel && i_re) ? w_rd_mux : 8'h00;
    assign o_pin_out  = r_out;
    assign o_pin_dir  = r_dir;
    assign o_int_pend = |(r_flags & r_mask);

endmodule
`default_nettype wire

// File: rtl/io_gpio.sv
`default_nettype none
// ============================================================================
// Module   : io_gpio
// Purpose  : GPIO peripheral on the 6-bit IO bus with PORTS banks of 8 pins.
//            Holds address decode, post-reset blanking counter, read-data OR
//            and the registered interrupt output.
// Ports    : clk, rst (async, active low)
//            io_re/io_we  bus strobes, io_addr bus address, io_out write data
//            io_in        read data, 8'h00 when not addressed
//            pin_in       raw pads, pin_out OUT registers, pin_dir DIR regs
//            irq          registered OR of enabled interrupt flags
// Revision : 1.0 - initial release
// ============================================================================
module io_gpio
    import io_gpio_pkg::*;
#(
    parameter int         BASE_ADDR   = 0,
    parameter int         PORTS       = 2,
    parameter int         SYNC_STAGES = 2,
    parameter int         EDGE_MODE   = 0,
    parameter logic [7:0] OUT_RESET   = 8'h00
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               io_re,
    input  logic               io_we,
    input  logic [5:0]         io_addr,
    input  logic [7:0]         io_out,
    output logic [7:0]         io_in,
    input  logic [PORTS*8-1:0] pin_in,
    output logic [PORTS*8-1:0] pin_out,
    output logic [PORTS*8-1:0] pin_dir,
    output logic               irq
);

    // BASE_ADDR is bank aligned, so a bank is selected by io_addr[5:3] alone.
    localparam int         c_first_bank = BASE_ADDR / c_bank_stride;
    // Blank until the first synchronised sample has also reached "prev",
    // so pins already high at reset release cannot look like a rising edge.
    localparam logic [2:0] c_blank_len  = 3'(SYNC_STAGES + 1);

    logic [2:0]       r_blank_cnt;
    logic             w_blank;
    logic [7:0]       w_rdata [PORTS];
    logic [PORTS-1:0] w_int_pend;

    assign w_blank = (r_blank_cnt < c_blank_len);

    // Counts up once after reset and then holds.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blank_cnt <= 3'd0;
        end else if (w_blank) begin
            r_blank_cnt <= r_blank_cnt + 3'd1;
        end
    end

    for (genvar p = 0; p < PORTS; p++) begin : g_bank
        localparam logic [2:0] c_bank_sel = 3'(c_first_bank + p);
        logic w_sel;

        assign w_sel = (io_addr[5:3] == c_bank_sel);

        io_gpio_bank #(
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE),
            .OUT_RESET   (OUT_RESET)
        ) u_bank (
            .clk        (clk),
            .rst        (rst),
            .i_sel      (w_sel),
            .i_offset   (io_addr[2:0]),
            .i_re       (io_re),
            .i_we       (io_we),
            .i_wdata    (io_out),
            .i_blank    (w_blank),
            .i_pin      (pin_in[p*8 +: 8]),
            .o_rdata    (w_rdata[p]),
            .o_pin_out  (pin_out[p*8 +: 8]),
            .o_pin_dir  (pin_dir[p*8 +: 8]),
            .o_int_pend (w_int_pend[p])
        );
    end

    // Unselected banks drive zero, so a plain OR merges them.
    always_comb begin
        io_in = 8'h00;
        for (int i = 0; i < PORTS; i++) begin
            io_in = io_in | w_rdata[i];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            irq <= 1'b0;
        end else begin
            irq <= |w_int_pend;
        end
    end

endmodule
`default_nettype wire
